program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-003 reset  input  1  SHALL be synchronous, active-high reset.
REQ-004 start  input  1  SHALL request a load; sampled only in IDLE, DONE, ERR.
REQ-005 byte_in  input  8  SHALL carry one stream byte.
REQ-006 byte_valid  input  1  SHALL qualify byte_in.
REQ-007 byte_ready  output  1  SHALL indicate the loader accepts a byte this cycle.
REQ-008 mem_we  output  1  SHALL be the instruction-memory write strobe, one cycle per word.
REQ-009 mem_addr  output  ADDR_WIDTH  SHALL be the word address written.
REQ-010 mem_wdata  output  32  SHALL be the assembled instruction word.
REQ-011 cpu_hold  output  1  SHALL stall the CPU program counter while high.
REQ-012 done  output  1  SHALL flag a successful load.
REQ-013 error  output  1  SHALL flag a failed load.

Function
REQ-014 Stream format SHALL be: count high byte, count low byte (N, 16-bit word count), 4N payload bytes (each word big-endian, MSB first), one checksum byte equal to XOR of all 4N payload bytes.
REQ-015 A byte SHALL be accepted only on a cycle with byte_valid && byte_ready; no other cycle changes state.
REQ-016 States SHALL be IDLE, HDR_HI, HDR_LO, DATA, CHECK, DONE, ERR.
REQ-017 byte_ready SHALL be 1 in HDR_HI, HDR_LO, DATA, CHECK and 0 in IDLE, DONE, ERR.
REQ-018 IDLE/DONE/ERR + start -> HDR_HI; word index, byte index, checksum accumulator cleared; done and error cleared.
REQ-019 HDR_HI + accept -> HDR_LO; HDR_LO + accept -> DATA if 1 <= N <= 2^ADDR_WIDTH, CHECK if N = 0, ERR if N > 2^ADDR_WIDTH.
REQ-020 DATA: each accepted byte SHALL shift into the word register and XOR into the accumulator; the 4th byte completes a word.
REQ-021 On word completion mem_we SHALL assert the following cycle for exactly one cycle with mem_addr = word index (0-based) and mem_wdata = assembled word; word index then increments.
REQ-022 After word N completes, state SHALL become CHECK; no wrap of mem_addr occurs.
REQ-023 CHECK + accept -> DONE if byte equals accumulator, else ERR.
REQ-024 cpu_hold SHALL be 0 only in DONE; done = 1 only in DONE; error = 1 only in ERR.
REQ-025 start asserted in HDR_HI, HDR_LO, DATA or CHECK SHALL be ignored.
REQ-026 Words already written before ERR SHALL remain in memory; no rollback.
REQ-027 Back-to-back valid bytes every cycle SHALL be sustained with no stall (throughput one byte/cycle).

Reset
REQ-028 reset SHALL force IDLE, byte_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_hold = 1, done = 0, error = 0, all counters and accumulator = 0.
REQ-029 reset mid-load SHALL abort immediately; a mem_we pending for the reset cycle SHALL NOT be issued.
REQ-030 reset SHALL take priority over start and byte acceptance in the same cycle.

Structure
REQ-031 State encodings and the header/checksum byte counts SHALL live in a shared loader package include file.
REQ-032 One sub-module, loader_byte_assembler (shift register plus byte counter plus XOR accumulator), SHALL be instantiated; FSM remains in program_loader.
REQ-033 Output connects to the existing instruction memory write port (mem_we/mem_addr/mem_wdata) and cpu_hold gates the CPU's PC write enable.

Verification
REQ-034 Reset, start, bytes 00 01 20 11 00 05 34 -> one mem_we at addr 0 data 0x20110005; done = 1, cpu_hold = 0.
REQ-035 Bytes 00 02 20 11 00 05 20 12 00 13 15 -> writes addr 0 = 0x20110005, addr 1 = 0x20120013; done = 1.
REQ-036 Same as REQ-034 with checksum 0x35 -> mem_we at addr 0 occurs, then error = 1, done = 0, cpu_hold = 1.
REQ-037 ADDR_WIDTH = 2, header 00 05 -> ERR after second byte, no mem_we, error = 1; header 00 00 then checksum 00 -> done = 1, no mem_we.
REQ-038 byte_valid toggled 1/0 randomly during REQ-035 stream -> identical writes; start pulsed mid-DATA -> ignored.
REQ-039 reset asserted on the cycle after 4th payload byte of REQ-034 -> no mem_we, IDLE, cpu_hold = 1; new start plus full stream -> done = 1.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding, stream
// framing constants and the checksum helper.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int CHK_BYTES      = 1;
  localparam int BYTES_PER_WORD = 4;

  // Running checksum: plain XOR of every payload byte.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake between the boot source and the program loader.
interface program_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Collects payload bytes MSB-first into 32-bit words, counts bytes within the
// word and keeps the XOR checksum of everything shifted in.
module loader_byte_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [7:0]  checksum,
  output logic        word_done
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [31:0] word_r;
  logic [1:0]  byte_idx_r;
  logic [7:0]  acc_r;

  // Shift register, byte index and checksum accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r     <= 32'h0000_0000;
      byte_idx_r <= 2'd0;
      acc_r      <= 8'h00;
    end else if (clear) begin
      word_r     <= 32'h0000_0000;
      byte_idx_r <= 2'd0;
      acc_r      <= 8'h00;
    end else if (shift_en) begin
      word_r     <= {word_r[23:0], byte_in};
      byte_idx_r <= byte_idx_r + 2'd1;
      acc_r      <= chk_update(acc_r, byte_in);
    end else begin
      word_r     <= word_r;
      byte_idx_r <= byte_idx_r;
      acc_r      <= acc_r;
    end
  end

  assign word      = word_r;
  assign checksum  = acc_r;
  assign word_done = shift_en && (byte_idx_r == LAST_IDX);

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, checksummed instruction image from a byte stream
// into instruction memory while holding the CPU program counter.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  program_loader_if.slave       stream,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  loader_state_e         state_r;
  logic                  byte_ready_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [31:0]           mem_wdata_r;
  logic                  cpu_hold_r;
  logic                  done_r;
  logic                  error_r;
  logic [7:0]            count_hi_r;
  logic [15:0]           count_r;
  logic [16:0]           word_cnt_r;
  logic                  wr_pend_r;
  logic [ADDR_WIDTH-1:0] pend_addr_r;

  logic                  accept_s;
  logic                  restart_s;
  logic                  shift_en_s;
  logic                  word_done_s;
  logic [31:0]           word_s;
  logic [7:0]            checksum_s;
  logic [16:0]           hdr_count_s;

  // Handshake qualification and per-state strobes to the assembler
  always_comb begin
    accept_s    = stream.byte_valid && byte_ready_r;
    restart_s   = 1'b0;
    shift_en_s  = 1'b0;
    hdr_count_s = {1'b0, count_hi_r, stream.byte_in};
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: restart_s  = start;
      ST_DATA:                  shift_en_s = accept_s;
      default: begin
        restart_s  = 1'b0;
        shift_en_s = 1'b0;
      end
    endcase
  end

  loader_byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (restart_s),
    .shift_en  (shift_en_s),
    .byte_in   (stream.byte_in),
    .word      (word_s),
    .checksum  (checksum_s),
    .word_done (word_done_s)
  );

  // Loader FSM; the memory write is staged one cycle behind word completion
  // so a reset arriving in that gap cancels it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r  <= 32'h0000_0000;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      count_hi_r   <= 8'h00;
      count_r      <= 16'h0000;
      word_cnt_r   <= 17'd0;
      wr_pend_r    <= 1'b0;
      pend_addr_r  <= {ADDR_WIDTH{1'b0}};
    end else begin
      mem_we_r  <= wr_pend_r;
      wr_pend_r <= 1'b0;
      if (wr_pend_r) begin
        mem_addr_r  <= pend_addr_r;
        mem_wdata_r <= word_s;
      end
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_r      <= ST_HDR_HI;
            byte_ready_r <= 1'b1;
            cpu_hold_r   <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            word_cnt_r   <= 17'd0;
            count_r      <= 16'h0000;
          end
        end
        ST_HDR_HI: begin
          if (accept_s) begin
            count_hi_r <= stream.byte_in;
            state_r    <= ST_HDR_LO;
          end
        end
        ST_HDR_LO: begin
          if (accept_s) begin
            count_r <= hdr_count_s[15:0];
            if (hdr_count_s == 17'd0) begin
              state_r <= ST_CHECK;
            end else if (hdr_count_s > CAPACITY) begin
              state_r      <= ST_ERR;
              byte_ready_r <= 1'b0;
              error_r      <= 1'b1;
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_done_s) begin
            wr_pend_r   <= 1'b1;
            pend_addr_r <= word_cnt_r[ADDR_WIDTH-1:0];
            word_cnt_r  <= word_cnt_r + 17'd1;
            if ((word_cnt_r + 17'd1) == {1'b0, count_r}) begin
              state_r <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (accept_s) begin
            byte_ready_r <= 1'b0;
            if (stream.byte_in == checksum_s) begin
              state_r    <= ST_DONE;
              done_r     <= 1'b1;
              cpu_hold_r <= 1'b0;
            end else begin
              state_r <= ST_ERR;
              error_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          byte_ready_r <= 1'b0;
          cpu_hold_r   <= 1'b1;
          done_r       <= 1'b0;
          error_r      <= 1'b0;
        end
      endcase
    end
  end

  assign stream.byte_ready = byte_ready_r;
  assign mem_we            = mem_we_r;
  assign mem_addr          = mem_addr_r;
  assign mem_wdata         = mem_wdata_r;
  assign cpu_hold          = cpu_hold_r;
  assign done              = done_r;
  assign error             = error_r;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (ADDR_WIDTH 10 and 2) share one
// stimulus stream; results are checked against a table and a stream model.
module tb_program_loader;
  import program_loader_pkg::*;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [191:0] bytes;
    int           len;
    bit           e_done;
    bit           e_err;
    int           e_nwr;
    logic [31:0]  w_first;
    int           last_addr;
    logic [31:0]  w_last;
    bit           s_done;
    bit           s_err;
    int           s_nwr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in_v = 8'h00;
  logic        byte_valid_v = 1'b0;

  logic        mem_we_a, cpu_hold_a, done_a, error_a;
  logic [9:0]  mem_addr_a;
  logic [31:0] mem_wdata_a;
  logic        mem_we_b, cpu_hold_b, done_b, error_b;
  logic [1:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] stim[$];
  wr_t got_a[$], got_b[$], exp_a[$], exp_b[$];
  vec_t vt[9];

  program_loader_if sif_a();
  program_loader_if sif_b();
  assign sif_a.byte_in    = byte_in_v;
  assign sif_a.byte_valid = byte_valid_v;
  assign sif_b.byte_in    = byte_in_v;
  assign sif_b.byte_valid = byte_valid_v;

  program_loader #(.ADDR_WIDTH(10)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stream(sif_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .cpu_hold(cpu_hold_a), .done(done_a), .error(error_a)
  );

  program_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stream(sif_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .cpu_hold(cpu_hold_b), .done(done_b), .error(error_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we_a) got_a.push_back('{addr: int'(mem_addr_a), data: mem_wdata_a});
    if (mem_we_b) got_b.push_back('{addr: int'(mem_addr_b), data: mem_wdata_b});
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    byte_valid_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    got_a.delete();
    got_b.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Present the first cnt bytes of stim; optional idle gaps and a start pulse.
  task automatic feed(input bit toggle, input int start_at, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (toggle) begin
        byte_valid_v = 1'b0;
        byte_in_v = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      byte_in_v = stim[i];
      byte_valid_v = 1'b1;
      start = (i == start_at);
      @(posedge clk);
      #1;
      byte_valid_v = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic load_row(input vec_t v);
    stim.delete();
    for (int i = 0; i < v.len; i++) stim.push_back(v.bytes[8*(v.len-1-i) +: 8]);
  endtask

  // Expected outcome of the whole stream for a memory of cap words.
  task automatic model(input bit which, output bit m_done, output bit m_err);
    wr_t q[$];
    int n, cap, need, base;
    logic [7:0] x;
    cap = which ? 4 : 1024;
    m_done = 1'b0;
    m_err = 1'b0;
    x = 8'h00;
    if (stim.size() >= HDR_BYTES) begin
      n = int'({stim[0], stim[1]});
      if (n > cap) begin
        m_err = 1'b1;
      end else begin
        for (int w = 0; w < n; w++) begin
          base = HDR_BYTES + 4*w;
          if (stim.size() >= base + 4)
            q.push_back('{addr: w, data: {stim[base], stim[base+1], stim[base+2], stim[base+3]}});
        end
        need = HDR_BYTES + 4*n + CHK_BYTES;
        if (stim.size() >= need) begin
          for (int i = HDR_BYTES; i < need - CHK_BYTES; i++) x = x ^ stim[i];
          m_done = (stim[need-1] == x);
          m_err = !m_done;
        end
      end
    end
    if (which) exp_b = q; else exp_a = q;
  endtask

  task automatic check_writes(input bit which, input string tag);
    wr_t g[$], e[$];
    if (which) begin g = got_b; e = exp_b; end
    else begin g = got_a; e = exp_a; end
    check({tag, "_nwr"}, 64'(g.size()), 64'(e.size()));
    for (int i = 0; i < g.size() && i < e.size(); i++) begin
      check({tag, "_addr"}, 64'(g[i].addr), 64'(e[i].addr));
      check({tag, "_data"}, 64'(g[i].data), 64'(e[i].data));
    end
  endtask

  task automatic check_model(input string tag);
    bit md, me;
    model(1'b0, md, me);
    check({tag, "_a_done"}, 64'(done_a), 64'(md));
    check({tag, "_a_err"}, 64'(error_a), 64'(me));
    check({tag, "_a_hold"}, 64'(cpu_hold_a), 64'(!md));
    check_writes(1'b0, {tag, "_a"});
    model(1'b1, md, me);
    check({tag, "_b_done"}, 64'(done_b), 64'(md));
    check({tag, "_b_err"}, 64'(error_b), 64'(me));
    check({tag, "_b_hold"}, 64'(cpu_hold_b), 64'(!md));
    check_writes(1'b1, {tag, "_b"});
  endtask

  initial begin
    int n, start_at;
    logic [7:0] x;
    vt[0] = '{192'h00012011000534, 7, 1'b1, 1'b0, 1, 32'h20110005, 0, 32'h20110005, 1'b1, 1'b0, 1};
    vt[1] = '{192'h0002201100052012001315, 11, 1'b1, 1'b0, 2, 32'h20110005, 1, 32'h20120013, 1'b1, 1'b0, 2};
    vt[2] = '{192'h00012011000535, 7, 1'b0, 1'b1, 1, 32'h20110005, 0, 32'h20110005, 1'b0, 1'b1, 1};
    vt[3] = '{192'h000000, 3, 1'b1, 1'b0, 0, 32'h0, 0, 32'h0, 1'b1, 1'b0, 0};
    vt[4] = '{192'h000001, 3, 1'b0, 1'b1, 0, 32'h0, 0, 32'h0, 1'b0, 1'b1, 0};
    vt[5] = '{192'h0005, 2, 1'b0, 1'b0, 0, 32'h0, 0, 32'h0, 1'b0, 1'b1, 0};
    vt[6] = '{192'h0401, 2, 1'b0, 1'b1, 0, 32'h0, 0, 32'h0, 1'b0, 1'b1, 0};
    vt[7] = '{192'h0400, 2, 1'b0, 1'b0, 0, 32'h0, 0, 32'h0, 1'b0, 1'b1, 0};
    vt[8] = '{192'h00040102030405060708090a0b0c0d0e0f1010, 19, 1'b1, 1'b0, 4,
              32'h01020304, 3, 32'h0d0e0f10, 1'b1, 1'b0, 4};

    do_reset();
    check("rst_ready", 64'(sif_a.byte_ready), 64'(0));
    check("rst_we", 64'(mem_we_a), 64'(0));
    check("rst_addr", 64'(mem_addr_a), 64'(0));
    check("rst_wdata", 64'(mem_wdata_a), 64'(0));
    check("rst_hold", 64'(cpu_hold_a), 64'(1));
    check("rst_done", 64'(done_a), 64'(0));
    check("rst_err", 64'(error_a), 64'(0));
    check("rst_hold_b", 64'(cpu_hold_b), 64'(1));

    for (int r = 0; r < 9; r++) begin
      do_reset();
      load_row(vt[r]);
      do_start();
      check($sformatf("row%0d_ready", r), 64'(sif_a.byte_ready), 64'(1));
      feed(1'b0, -1, stim.size());
      settle();
      check($sformatf("row%0d_done", r), 64'(done_a), 64'(vt[r].e_done));
      check($sformatf("row%0d_err", r), 64'(error_a), 64'(vt[r].e_err));
      check($sformatf("row%0d_hold", r), 64'(cpu_hold_a), 64'(!vt[r].e_done));
      check($sformatf("row%0d_nwr", r), 64'(got_a.size()), 64'(vt[r].e_nwr));
      if (vt[r].e_nwr > 0 && got_a.size() > 0) begin
        check($sformatf("row%0d_first", r), 64'(got_a[0].data), 64'(vt[r].w_first));
        check($sformatf("row%0d_first_addr", r), 64'(got_a[0].addr), 64'(0));
        check($sformatf("row%0d_last", r), 64'(got_a[got_a.size()-1].data), 64'(vt[r].w_last));
        check($sformatf("row%0d_last_addr", r), 64'(got_a[got_a.size()-1].addr), 64'(vt[r].last_addr));
      end
      check($sformatf("row%0d_b_done", r), 64'(done_b), 64'(vt[r].s_done));
      check($sformatf("row%0d_b_err", r), 64'(error_b), 64'(vt[r].s_err));
      check($sformatf("row%0d_b_nwr", r), 64'(got_b.size()), 64'(vt[r].s_nwr));
    end

    // Gappy valid plus a start pulse in the middle of the payload.
    do_reset();
    load_row(vt[1]);
    do_start();
    feed(1'b1, 5, stim.size());
    settle();
    check_model("gap_start");

    // Reset in the cycle after the 4th payload byte cancels the write.
    do_reset();
    load_row(vt[0]);
    do_start();
    feed(1'b0, -1, 6);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    settle();
    check("rstmid_nwr", 64'(got_a.size()), 64'(0));
    check("rstmid_hold", 64'(cpu_hold_a), 64'(1));
    check("rstmid_ready", 64'(sif_a.byte_ready), 64'(0));
    check("rstmid_done", 64'(done_a), 64'(0));
    do_start();
    feed(1'b0, -1, stim.size());
    settle();
    check_model("rstmid_reload");

    // Restart straight from DONE clears the status flags.
    got_a.delete();
    got_b.delete();
    load_row(vt[1]);
    do_start();
    check("restart_done", 64'(done_a), 64'(0));
    check("restart_hold", 64'(cpu_hold_a), 64'(1));
    check("restart_ready", 64'(sif_a.byte_ready), 64'(1));
    feed(1'b0, -1, stim.size());
    settle();
    check_model("restart");

    for (int it = 0; it < 24; it++) begin
      n = $urandom_range(0, 6);
      stim.delete();
      stim.push_back(8'h00);
      stim.push_back(8'(n));
      x = 8'h00;
      for (int i = 0; i < 4*n; i++) begin
        stim.push_back(8'($urandom));
        x = x ^ stim[stim.size()-1];
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
      stim.push_back(x);
      start_at = (n >= 1 && n <= 4 && $urandom_range(0, 1) == 1) ? $urandom_range(2, 4*n + 1) : -1;
      if ($urandom_range(0, 1) == 1) begin
        do_reset();
      end else begin
        got_a.delete();
        got_b.delete();
      end
      do_start();
      feed(1'b1, start_at, stim.size());
      settle();
      check_model($sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
